// File: rtl/fft_stream_pkg.sv
// rtl/fft_stream_pkg.sv - shared types, constants and helpers for the FFT result streamer
package fft_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } stream_state_t;

    // Output buffer depth; the read credit scheme is sized around it.
    localparam int FIFO_DEPTH = 2;

    // Widest address the bit-reverse helper supports.
    localparam int MAX_ADDR_W = 16;

    // Mirror the low `width` bits of `value`; bits above `width` come back as 0.
    function automatic logic [MAX_ADDR_W-1:0] bit_reverse(
        input logic [MAX_ADDR_W-1:0] value,
        input int                    width
    );
        logic [MAX_ADDR_W-1:0] mirrored;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            mirrored[i] = value[MAX_ADDR_W-1-i];
        end
        return mirrored >> (MAX_ADDR_W - width);
    endfunction

endpackage

// File: rtl/fft_result_streamer_if.sv
// rtl/fft_result_streamer_if.sv - result memory read port plus output bin stream
interface fft_result_streamer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic                  mem_rd_en_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [2*DATA_W-1:0]   mem_rdata_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [2*DATA_W-1:0]   out_data_o;
    logic [ADDR_W-1:0]     out_idx_o;
    logic                  out_last_o;

    // Streamer side: drives the memory read port and the bin stream.
    modport master (
        output mem_rd_en_o,
        output mem_addr_o,
        input  mem_rdata_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
        output out_idx_o,
        output out_last_o
    );

    // Memory / consumer side.
    modport slave (
        input  mem_rd_en_o,
        input  mem_addr_o,
        output mem_rdata_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
        input  out_idx_o,
        input  out_last_o
    );
endinterface

// File: rtl/fft_out_fifo.sv
// rtl/fft_out_fifo.sv - 2-entry synchronous FIFO of {last, idx, data} entries
module fft_out_fifo
    import fft_stream_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] slot0_q;
    logic [WIDTH-1:0] slot1_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;
    logic             do_push;

    // Pops on an empty buffer and pushes into a full one (without a pop) are dropped.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);

    assign head_o  = slot0_q;
    assign count_o = count_q;

    // Slot 0 is always the head; a pop shifts slot 1 forward so order is preserved.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == '0) begin
                        slot0_q <= push_data_i;
                    end else begin
                        slot1_q <= push_data_i;
                    end
                    count_q <= count_q + CNT_W'(1);
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - CNT_W'(1);
                end
                2'b11: begin
                    if (count_q == CNT_W'(1)) begin
                        slot0_q <= push_data_i;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fft_result_streamer.sv
// rtl/fft_result_streamer.sv - drains the FFT result memory as a natural-order bin stream
module fft_result_streamer
    import fft_stream_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int DATA_W   = 16,
    parameter bit BITREV   = 1'b1,
    parameter int ADDR_W   = $clog2(N_POINTS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   done_i,
    fft_result_streamer_if.master  bus,
    output logic                   busy_o,
    output logic                   rd_done_o,
    output logic                   ovr_o
);

    localparam int ENTRY_W = 2 * DATA_W + ADDR_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    stream_state_t      state_q;
    logic [ADDR_W:0]    rd_cnt_q;
    logic               inflight_q;
    logic [ADDR_W-1:0]  rd_idx_q;
    logic               rd_done_q;
    logic               ovr_q;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] push_entry;
    logic [CNT_W:0]     occupancy;
    logic [ADDR_W-1:0]  lin_addr;
    logic               pop;
    logic               rd_en;

    // Handshake and read credit: buffered + in-flight entries, minus the one leaving now.
    assign bus.out_valid_o = (fifo_count != '0);
    assign pop             = bus.out_valid_o & bus.out_ready_i;
    assign occupancy       = {1'b0, fifo_count}
                           + {{CNT_W{1'b0}}, inflight_q}
                           - {{CNT_W{1'b0}}, pop};
    assign rd_en           = (state_q == STREAM) && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    // Address generation: counter walks natural order, memory may hold bit-reversed order.
    assign lin_addr        = rd_cnt_q[ADDR_W-1:0];
    assign bus.mem_rd_en_o = rd_en;
    assign bus.mem_addr_o  = BITREV ? ADDR_W'(bit_reverse(MAX_ADDR_W'(lin_addr), ADDR_W))
                                    : lin_addr;

    // Read data lands one cycle after the strobe, tagged with the index captured then.
    assign push_entry = {(rd_idx_q == ADDR_W'(N_POINTS - 1)), rd_idx_q, bus.mem_rdata_i};

    fft_out_fifo #(
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign {bus.out_last_o, bus.out_idx_o, bus.out_data_o} = fifo_head;

    assign busy_o    = (state_q != IDLE);
    assign rd_done_o = rd_done_q;
    assign ovr_o     = ovr_q;

    // Frame FSM with read counter, in-flight flag and registered status pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            inflight_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_done_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rd_done_q  <= 1'b0;
            ovr_q      <= 1'b0;
            inflight_q <= rd_en;
            if (rd_en) begin
                rd_cnt_q <= rd_cnt_q + (ADDR_W + 1)'(1);
                rd_idx_q <= lin_addr;
            end
            case (state_q)
                IDLE: begin
                    if (done_i) begin
                        state_q  <= STREAM;
                        rd_cnt_q <= '0;
                    end
                end
                STREAM: begin
                    if (done_i) begin
                        ovr_q <= 1'b1;
                    end
                    if (rd_en && (rd_cnt_q == (ADDR_W + 1)'(N_POINTS - 1))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done_i) begin
                        ovr_q <= 1'b1;
                    end
                    if (pop && bus.out_last_o) begin
                        state_q   <= IDLE;
                        rd_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_streamer.sv
// tb/tb_fft_result_streamer.sv - self-checking bench for fft_result_streamer
module tb_fft_result_streamer;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic done  = 1'b0;
    logic ready = 1'b0;

    fft_result_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    fft_result_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    logic busy1, rd_done1, ovr1;
    logic busy0, rd_done0, ovr0;

    fft_result_streamer #(.N_POINTS(N), .DATA_W(DW), .BITREV(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .done_i(done), .bus(bus1),
        .busy_o(busy1), .rd_done_o(rd_done1), .ovr_o(ovr1)
    );

    fft_result_streamer #(.N_POINTS(N), .DATA_W(DW), .BITREV(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .done_i(done), .bus(bus0),
        .busy_o(busy0), .rd_done_o(rd_done0), .ovr_o(ovr0)
    );

    assign bus1.out_ready_i = ready;
    assign bus0.out_ready_i = ready;

    // Memory models: {addr, ~addr} one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        bus1.mem_rdata_i <= bus1.mem_rd_en_o ? {16'(bus1.mem_addr_o), ~16'(bus1.mem_addr_o)} : 32'($urandom);
        bus0.mem_rdata_i <= bus0.mem_rd_en_o ? {16'(bus0.mem_addr_o), ~16'(bus0.mem_addr_o)} : 32'($urandom);
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: reads issued, reads whose data has landed, bins delivered.
    int issued    = 0;
    int landed    = 0;
    int popped    = 0;
    bit busy_m    = 1'b0;
    bit rd_done_m = 1'b0;
    bit ovr_m     = 1'b0;
    bit after_rst = 1'b1;
    int dut_pops  = 0;

    int done_q[$];
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int pop_cyc_q[$];
    int pop_idx_q[$];
    int pop_re0_q[$];
    int last_q[$];
    int rd_done_q[$];
    int ovr_q[$];

    int exp_rev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int phys(input int i, input int br);
        if (br != 0) return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
        return i;
    endfunction

    function automatic logic [31:0] exp_data(input int i, input int br);
        logic [15:0] p;
        p = 16'(phys(i, br));
        return {p, ~p};
    endfunction

    task automatic check_dut(input string tag, input int br, input bit rd_e, input bit vld_e,
                             input logic rd_en, input logic [2:0] addr, input logic vld,
                             input logic [31:0] data, input logic [2:0] idx, input logic last,
                             input logic busy, input logic rdd, input logic ovr);
        chk({tag, "_rd_en"}, rd_en, rd_e);
        if (rd_e) chk({tag, "_addr"}, addr, phys(issued, br));
        chk({tag, "_valid"}, vld, vld_e);
        if (vld_e) begin
            chk({tag, "_idx"}, idx, popped);
            chk({tag, "_data"}, data, exp_data(popped, br));
            chk({tag, "_last"}, last, popped == N - 1);
        end
        chk({tag, "_busy"}, busy, busy_m);
        chk({tag, "_rd_done"}, rdd, rd_done_m);
        chk({tag, "_ovr"}, ovr, ovr_m);
        if (after_rst) begin
            chk({tag, "_rst_addr"}, addr, 0);
            chk({tag, "_rst_data"}, data, 0);
            chk({tag, "_rst_idx"}, idx, 0);
            chk({tag, "_rst_last"}, last, 0);
        end
    endtask

    // Per-cycle comparison against the model, event logging, then model advance.
    always @(negedge clk) begin
        bit vld_e, pop_e, rd_e;
        vld_e = landed > popped;
        pop_e = vld_e && ready;
        rd_e  = busy_m && (issued < N) && ((issued - popped - (pop_e ? 1 : 0)) < 2);

        check_dut("b1", 1, rd_e, vld_e, bus1.mem_rd_en_o, bus1.mem_addr_o, bus1.out_valid_o,
                  bus1.out_data_o, bus1.out_idx_o, bus1.out_last_o, busy1, rd_done1, ovr1);
        check_dut("b0", 0, rd_e, vld_e, bus0.mem_rd_en_o, bus0.mem_addr_o, bus0.out_valid_o,
                  bus0.out_data_o, bus0.out_idx_o, bus0.out_last_o, busy0, rd_done0, ovr0);

        if (done) done_q.push_back(cyc);
        if (bus1.mem_rd_en_o) begin
            rd_addr_q.push_back(int'(bus1.mem_addr_o));
            rd_cyc_q.push_back(cyc);
        end
        if (rd_done1) begin
            rd_done_q.push_back(cyc);
            chk("frame_len", dut_pops, N);
        end
        if (bus1.out_valid_o && ready) begin
            pop_cyc_q.push_back(cyc);
            pop_idx_q.push_back(int'(bus1.out_idx_o));
            pop_re0_q.push_back(int'(bus0.out_data_o[31:16]));
            dut_pops++;
            if (bus1.out_last_o) last_q.push_back(cyc);
        end
        if (ovr1) ovr_q.push_back(cyc);

        if (rst) begin
            issued = 0; landed = 0; popped = 0;
            busy_m = 0; rd_done_m = 0; ovr_m = 0;
            after_rst = 1; dut_pops = 0;
        end else begin
            after_rst = 0;
            rd_done_m = pop_e && (popped == N - 1);
            ovr_m     = done && busy_m;
            landed    = issued;
            if (rd_e) issued++;
            if (pop_e) popped++;
            if (rd_done_m) begin
                busy_m = 0;
            end else if (!busy_m && done) begin
                busy_m = 1; issued = 0; landed = 0; popped = 0; dut_pops = 0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic wait_rd_done(input int bound);
        int k = 0;
        while (!rd_done1 && k < bound) begin
            step();
            k++;
        end
        chk("rd_done_wait", rd_done1, 1);
    endtask

    task automatic clear_logs();
        done_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
        pop_cyc_q.delete(); pop_idx_q.delete(); pop_re0_q.delete();
        last_q.delete(); rd_done_q.delete(); ovr_q.delete();
    endtask

    initial begin
        int t0;
        int k;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Full-rate frame: literal address order and latencies.
        ready = 1'b1;
        clear_logs();
        pulse_done();
        wait_rd_done(40);
        repeat (2) step();
        t0 = (done_q.size() > 0) ? done_q[0] : 0;
        chk("s1_reads", rd_addr_q.size(), 8);
        chk("s1_pops", pop_cyc_q.size(), 8);
        if (rd_addr_q.size() == 8 && pop_cyc_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("s1_addr", rd_addr_q[i], exp_rev[i]);
                chk("s1_rd_cyc", rd_cyc_q[i], t0 + 1 + i);
                chk("s1_pop_cyc", pop_cyc_q[i], t0 + 3 + i);
                chk("s1_pop_idx", pop_idx_q[i], i);
                chk("s1_lin_re", pop_re0_q[i], i);
            end
        end
        if (last_q.size() > 0) chk("s1_last_cyc", last_q[0], t0 + 10);
        else chk("s1_last_seen", 0, 1);
        if (rd_done_q.size() > 0) chk("s1_rd_done_cyc", rd_done_q[0], t0 + 11);
        else chk("s1_rd_done_seen", 0, 1);

        // Backpressure at start: two reads only, then full rate on release.
        ready = 1'b0;
        clear_logs();
        pulse_done();
        repeat (9) step();
        chk("s2_reads_stalled", rd_cyc_q.size(), 2);
        ready = 1'b1;
        wait_rd_done(40);
        step();
        chk("s2_pops", pop_cyc_q.size(), 8);
        if (pop_cyc_q.size() == 8 && rd_cyc_q.size() == 8) begin
            chk("s2_resume", rd_cyc_q[2], pop_cyc_q[0]);
            for (int i = 1; i < 8; i++) chk("s2_rate", pop_cyc_q[i], pop_cyc_q[0] + i);
        end

        // done while busy: overrun pulse, frame untouched.
        clear_logs();
        pulse_done();
        repeat (4) step();
        pulse_done();
        wait_rd_done(40);
        step();
        chk("s3_ovr_count", ovr_q.size(), 1);
        if (ovr_q.size() == 1 && done_q.size() == 2) chk("s3_ovr_cyc", ovr_q[0], done_q[0] + 6);
        if (rd_done_q.size() > 0 && done_q.size() > 0) chk("s3_rd_done_cyc", rd_done_q[0], done_q[0] + 11);
        chk("s3_pops", pop_cyc_q.size(), 8);

        // done coincident with rd_done starts the next frame immediately.
        clear_logs();
        pulse_done();
        wait_rd_done(40);
        pulse_done();
        wait_rd_done(40);
        step();
        chk("s4_frames", rd_done_q.size(), 2);
        chk("s4_reads", rd_cyc_q.size(), 16);
        chk("s4_ovr_none", ovr_q.size(), 0);
        if (rd_done_q.size() == 2 && rd_cyc_q.size() == 16) begin
            chk("s4_restart", rd_cyc_q[8], rd_done_q[0] + 1);
            chk("s4_second_end", rd_done_q[1], rd_done_q[0] + 11);
        end

        // Reset mid-frame after three bins, then a clean frame.
        clear_logs();
        pulse_done();
        k = 0;
        while (pop_cyc_q.size() < 3 && k < 40) begin
            step();
            k++;
        end
        chk("s5_three_pops", pop_cyc_q.size() >= 3, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_busy_cleared", busy1, 0);
        chk("s5_valid_cleared", bus1.out_valid_o, 0);
        clear_logs();
        step();
        pulse_done();
        wait_rd_done(40);
        step();
        chk("s5_pops", pop_idx_q.size(), 8);
        if (pop_idx_q.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("s5_idx", pop_idx_q[i], i);
        end

        // Random ready, spurious done pulses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            ready = 1'($urandom_range(0, 1));
            done  = ($urandom_range(0, 11) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            step();
        end
        ready = 1'b1;
        done  = 1'b0;
        rst   = 1'b0;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
